// File: rtl/store_buffer_pkg.sv
// Shared types for the retired-store buffer: entry layout, drain FSM states,
// load/store func3 encodings and helpers that map func3 + address to byte lanes.
package store_buffer_pkg;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        valid;
    } sb_entry_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_ISSUE
    } drain_state_t;

    function automatic logic store_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_SB:   return 1'b0;
            F3_SH:   return lo[0];
            F3_SW:   return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Store data is replicated across lanes so memory and forwarding can pick any lane.
    function automatic sb_entry_t make_entry(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [2:0] f3);
        sb_entry_t e;
        e       = '0;
        e.waddr = addr[31:2];
        e.valid = 1'b1;
        case (f3)
            F3_SB: begin
                e.be   = 4'b0001 << addr[1:0];
                e.data = {4{data[7:0]}};
            end
            F3_SH: begin
                e.be   = addr[1] ? 4'b1100 : 4'b0011;
                e.data = {2{data[15:0]}};
            end
            F3_SW: begin
                e.be   = 4'b1111;
                e.data = data;
            end
            default: begin
                e.be   = 4'b0000;
                e.data = 32'h0;
            end
        endcase
        return e;
    endfunction

    function automatic logic [3:0] load_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_LB, F3_LBU: return 4'b0001 << lo;
            F3_LH, F3_LHU: return lo[1] ? 4'b1100 : 4'b0011;
            F3_LW:         return 4'b1111;
            default:       return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/sb_fwd_extract.sv
// Pulls the addressed byte/halfword/word out of a forwarded store word and
// sign- or zero-extends it according to the load func3.
module sb_fwd_extract
    import store_buffer_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byte_sel,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_byte_sel)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_byte_sel[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_func3)
            F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_value = {24'h0, w_byte};
            F3_LH:   o_value = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_value = {16'h0, w_half};
            F3_LW:   o_value = i_word;
            default: o_value = 32'h0;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Retired-store FIFO: accepts committed stores, drains them in order to data
// memory, and forwards (or stalls) younger loads that overlap buffered bytes.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_commit_valid,
    input  logic [31:0]              i_commit_addr,
    input  logic [31:0]              i_commit_data,
    input  logic [2:0]               i_commit_func3,
    output logic                     o_commit_ready,
    output logic                     o_commit_misaligned,
    output logic                     o_mem_wr_valid,
    output logic [31:0]              o_mem_wr_addr,
    output logic [31:0]              o_mem_wr_data,
    output logic [3:0]               o_mem_wr_be,
    input  logic                     i_mem_wr_ready,
    input  logic                     i_ld_query_valid,
    input  logic [31:0]              i_ld_query_addr,
    input  logic [2:0]               i_ld_query_func3,
    output logic                     o_ld_fwd_hit,
    output logic [31:0]              o_ld_fwd_data,
    output logic                     o_ld_stall,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int            PW        = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL  = DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE   = 1;
    localparam logic [PW:0]   CNT_ZERO  = 0;

    sb_entry_t      r_entries [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [PW:0]    r_count;
    logic           r_misaligned;
    drain_state_t   r_state;
    logic           r_wr_valid;
    logic [31:0]    r_wr_addr;
    logic [31:0]    r_wr_data;
    logic [3:0]     r_wr_be;

    logic           w_commit_fire;
    logic           w_commit_mis;
    logic           w_enq;
    logic           w_deq;
    sb_entry_t      w_new_entry;
    logic [PW-1:0]  w_head_nxt;
    sb_entry_t      w_issue_src;
    logic           w_issue_ok;

    assign o_commit_ready = (r_count != CNT_FULL);
    assign w_commit_fire  = i_commit_valid && o_commit_ready;
    assign w_commit_mis   = store_misaligned(i_commit_func3, i_commit_addr[1:0]);
    assign w_enq          = w_commit_fire && !w_commit_mis;
    assign w_deq          = r_wr_valid && i_mem_wr_ready;
    assign w_new_entry    = make_entry(i_commit_addr, i_commit_data, i_commit_func3);
    assign w_head_nxt     = r_head + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_commit_fire && w_commit_mis;
            if (w_enq) begin
                r_entries[r_tail] <= w_new_entry;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= w_head_nxt;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next entry to present: the buffered head/successor, or the store being
    // enqueued this cycle when nothing older is waiting behind it.
    always_comb begin
        w_issue_src = w_new_entry;
        w_issue_ok  = w_enq;
        if (r_state == DRAIN_IDLE) begin
            if (r_count != CNT_ZERO) begin
                w_issue_src = r_entries[r_head];
                w_issue_ok  = 1'b1;
            end
        end else if (r_count > CNT_ONE) begin
            w_issue_src = r_entries[w_head_nxt];
            w_issue_ok  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= DRAIN_IDLE;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_be    <= '0;
        end else begin
            case (r_state)
                DRAIN_IDLE: begin
                    if (w_issue_ok) begin
                        r_state    <= DRAIN_ISSUE;
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= {w_issue_src.waddr, 2'b00};
                        r_wr_data  <= w_issue_src.data;
                        r_wr_be    <= w_issue_src.be;
                    end
                end
                DRAIN_ISSUE: begin
                    if (i_mem_wr_ready) begin
                        if (w_issue_ok) begin
                            r_wr_addr <= {w_issue_src.waddr, 2'b00};
                            r_wr_data <= w_issue_src.data;
                            r_wr_be   <= w_issue_src.be;
                        end else begin
                            r_state    <= DRAIN_IDLE;
                            r_wr_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= DRAIN_IDLE;
                    r_wr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_commit_misaligned = r_misaligned;
    assign o_mem_wr_valid      = r_wr_valid;
    assign o_mem_wr_addr       = r_wr_addr;
    assign o_mem_wr_data       = r_wr_data;
    assign o_mem_wr_be         = r_wr_be;
    assign o_empty             = (r_count == CNT_ZERO);
    assign o_count             = r_count;

    logic [3:0]      w_ld_be;
    logic [DEPTH-1:0] w_match;
    logic [PW-1:0]   w_scan_idx;
    logic            w_fwd_found;
    logic [31:0]     w_fwd_word;
    logic [3:0]      w_fwd_be;
    logic            w_fwd_cover;
    logic [31:0]     w_fwd_value;

    assign w_ld_be = load_be(i_ld_query_func3, i_ld_query_addr[1:0]);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_entries[gi].valid
                              && (r_entries[gi].waddr == i_ld_query_addr[31:2])
                              && |(r_entries[gi].be & w_ld_be);
        end
    endgenerate

    // Walk oldest to youngest; the last match seen is the youngest overlapping store.
    always_comb begin
        w_fwd_found = 1'b0;
        w_fwd_word  = '0;
        w_fwd_be    = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = r_head + PW'(k);
            if (w_match[w_scan_idx]) begin
                w_fwd_found = 1'b1;
                w_fwd_word  = r_entries[w_scan_idx].data;
                w_fwd_be    = r_entries[w_scan_idx].be;
            end
        end
    end

    assign w_fwd_cover = ((w_fwd_be & w_ld_be) == w_ld_be);

    sb_fwd_extract u_extract (
        .i_word     (w_fwd_word),
        .i_byte_sel (i_ld_query_addr[1:0]),
        .i_func3    (i_ld_query_func3),
        .o_value    (w_fwd_value)
    );

    assign o_ld_fwd_hit  = i_ld_query_valid && w_fwd_found && w_fwd_cover;
    assign o_ld_stall    = i_ld_query_valid && w_fwd_found && !w_fwd_cover;
    assign o_ld_fwd_data = o_ld_fwd_hit ? w_fwd_value : 32'h0;

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of retired-store entries (power of two, 2..8).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 commit_valid  in  1  ROB-retired store presented.
REQ-005 commit_addr  in  32  byte address (base + imm).
REQ-006 commit_data  in  32  ps2 store data, low bits significant for SB/SH.
REQ-007 commit_func3  in  3  000 SB, 001 SH, 010 SW.
REQ-008 commit_ready  out  1  entry free; commit accepted when valid && ready.
REQ-009 commit_misaligned  out  1  one-cycle pulse: accepted commit was misaligned and dropped.
REQ-010 mem_wr_valid  out  1  write request to data memory.
REQ-011 mem_wr_addr  out  32  word-aligned address (addr[1:0]=00).
REQ-012 mem_wr_data  out  32  lane-positioned write data.
REQ-013 mem_wr_be  out  4  byte enables.
REQ-014 mem_wr_ready  in  1  memory accepts write when valid && ready.
REQ-015 ld_query_valid  in  1  load lookup from fu_mem.
REQ-016 ld_query_addr  in  32  load byte address.
REQ-017 ld_query_func3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-018 ld_fwd_hit  out  1  buffer fully supplies load bytes.
REQ-019 ld_fwd_data  out  32  extended forwarded value, 0 when no hit.
REQ-020 ld_stall  out  1  partial overlap; load must retry.
REQ-021 empty  out  1 / count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-022 Circular FIFO; head/tail pointers wrap modulo DEPTH; commit_ready = (count != DEPTH), from registered state only (no same-cycle bypass when full).
REQ-023 Enqueue: SB be = 1<<addr[1:0], data byte replicated to all lanes; SH be = addr[1] ? 1100 : 0011, halfword replicated; SW be = 1111.
REQ-024 Misaligned (SH with addr[0]=1, SW with addr[1:0]!=0, or other func3): not enqueued, commit_misaligned pulses next cycle, commit still handshaken.
REQ-025 Drain FSM IDLE/ISSUE: IDLE->ISSUE when !empty; ISSUE holds mem_wr_* stable from head entry until mem_wr_ready; on handshake pop head, stay ISSUE if entries remain, else IDLE.
REQ-026 Latency: store accepted at edge N presents mem_wr_valid in cycle after N (earliest).
REQ-027 Simultaneous commit and drain handshake: count unchanged, both pointers advance.
REQ-028 Forwarding combinational, same cycle: scan youngest to oldest for first entry with same word address and be overlapping load bytes.
REQ-029 If that entry's be covers all load bytes: ld_fwd_hit=1, data extracted and sign/zero-extended per func3; if overlap but not covering: ld_stall=1, hit=0; no overlapping entry: both 0.
REQ-030 Outputs ld_fwd_hit, ld_stall forced 0 when ld_query_valid=0.
REQ-031 Mispredict does not affect contents; all entries are retired.

Reset
REQ-032 Reset clears pointers, count=0, FSM=IDLE, entries' valid bits.
REQ-033 Reset values: commit_ready=1, empty=1, mem_wr_valid=0, mem_wr_addr/data/be=0, commit_misaligned=0, ld_fwd_hit=0, ld_stall=0, ld_fwd_data=0.
REQ-034 Reset during ISSUE abandons in-flight write; mem_wr_valid drops immediately (async).

Structure
REQ-035 types_pkg gains sb_entry struct (word addr, data, be, valid) and func3 load/store constants.
REQ-036 One sub-module sb_fwd_extract: byte/half selection plus sign/zero extension, combinational.

Verification
REQ-037 SW 0xDEADBEEF @16, mem_wr_ready=0, LW query @16 -> hit=1, data 0xDEADBEEF; release ready -> one write addr 16, be 1111.
REQ-038 SH 0x0000BEEF @34 -> mem_wr_addr 32, be 1100, data 0xBEEFBEEF; LW query @32 -> stall=1, hit=0.
REQ-039 SW 0x112233AA @40; LBU @40 -> 0x000000AA; SW 0x11223380 @40; LB @40 -> 0xFFFFFF80 (youngest wins).
REQ-040 mem_wr_ready=0, four commits -> commit_ready=0, count=4; fifth held; one handshake -> ready=1 next cycle, FIFO order preserved across wrap.
REQ-041 SW @18 -> commit_misaligned pulse, count unchanged, no memory write.
REQ-042 Reset asserted mid-ISSUE with 3 entries -> mem_wr_valid=0, empty=1, count=0 immediately.
